pipe_reg_skid: RTL and testbench
================================

# pipe_reg_skid

Parametrised execute→writeback pipeline register that replaces the single-entry clear/hold register with a two-entry skid buffer. It adds a valid/ready handshake on both sides, a synchronous flush, a sticky halt latch and an occupancy count. Upstream may stall or flush independently of downstream without losing or duplicating an instruction. Strict in-order delivery.

## Interface
- A_BITS, 10, width of jump target / jmp_val
- D_BITS, 32, width of result
- R_BITS, 3, width of destination register index
- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of both entries and halt latch
- in_valid  in  1  upstream entry offered
- in_ready  out  1  stage can accept this cycle
- in_result / in_dest / in_jmp_val  in  D_BITS / R_BITS / A_BITS  payload
- in_write_en, in_read, in_jmp_op, in_jmp_relative_op, in_halt_op  in  1 each  payload flags
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_result / out_dest / out_jmp_val  out  D_BITS / R_BITS / A_BITS  head payload
- out_write_en, out_read, out_jmp_op, out_jmp_relative_op, out_halt_op  out  1 each  head flags
- halted  out  1  a halt_op entry has been accepted, input closed
- occupancy  out  2  number of valid entries, 0..2

## Operation
- Two entries: main (drives out_*) and skid. in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid & !halted, taken from registers only; there is no combinational path from out_ready.
- Main empty, in_fire → load main.
- Main full, out_fire & in_fire → main loads input.
- Main full, !out_fire & in_fire → input goes to skid.
- Main full, out_fire, no in_fire → main loads skid if skid is valid, otherwise main empties.
- Skid full, out_fire → main loads skid and skid empties. in_ready is 0 while skid is full, so no input is taken in the same cycle.
- Payload registers update only on load and retain their value otherwise. out_* is meaningful only when out_valid=1.
- Halt: in_fire with in_halt_op=1 sets halted the next cycle, which forces in_ready=0. The halt entry still drains normally. halted clears only on flush or reset.
- Flush (priority over all transfers): main_valid, skid_valid and halted go to 0 and payloads go to 0 on the next edge. An in_fire in the flush cycle is discarded; upstream treats it as consumed. An out_fire in the flush cycle counts as delivered.
- occupancy = main_valid + skid_valid.

## Timing
- Reset (nrst low, asynchronous): out_valid=0, out_* payload=0, halted=0, occupancy=0. in_ready=1 combinationally from the reset registers.
- Latency: 1 cycle from in_fire to out_valid with an empty stage. Throughput is 1 entry/cycle with out_ready held high.
- After out_ready deasserts, exactly one further entry is absorbed (into skid), then in_ready drops on the following cycle.
- Reset asserted mid-transfer drops all entries; the first acceptance is on the first edge after nrst rises.
- Flush and halt in the same cycle: flush wins, so halted=0 afterwards.

## Structure
- Shared package: payload field widths and a packed payload type. The type's field order is result, dest, write_en, read, jmp_op, jmp_relative_op, jmp_val, halt_op. The package also holds the zero-payload constant.
- Sub-module pipe_slot, instantiated twice (main, skid):
  - one valid bit plus a payload register;
  - ports: load, clear, load data;
  - clear takes priority over load.
- The top level holds the transfer control, the halt latch and the occupancy logic.

## Test plan
- Reset, then stream 4 entries with results 0x11..0x14 and out_ready=1 → out_valid from cycle 1, results appear in order one per cycle, occupancy ≤1.
- out_ready=0 while sending 0xA1, 0xA2, 0xA3 → 0xA1 in main, 0xA2 in skid, in_ready=0 and 0xA3 held upstream. Raise out_ready → 0xA1, 0xA2, 0xA3 delivered in order with no loss or duplicates.
- Send an entry with in_halt_op=1 and dest=5, followed by more valid entries → halted=1 the next cycle and in_ready=0. The halt entry drains with out_halt_op=1; later entries are never accepted.
- Fill both entries, then pulse flush with in_valid=1 → next cycle out_valid=0, occupancy=0, payload=0, in_ready=1, and the flush-cycle input does not appear.
- Drop nrst asynchronously mid-clock with 2 entries held and halted=1 → all outputs go to their reset values immediately, before the next edge.
- out_ready toggling randomly against a random in_valid pattern for 1000 cycles → scoreboard shows in-order delivery, no drops or duplicates, and in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_reg_skid_pkg.sv
// pipe_reg_skid_pkg: payload widths, packed payload type and zero constant for the execute->writeback skid register
package pipe_reg_skid_pkg;
  localparam int A_BITS_DEF = 10;
  localparam int D_BITS_DEF = 32;
  localparam int R_BITS_DEF = 3;
  typedef struct packed {
    logic [D_BITS_DEF-1:0] result;
    logic [R_BITS_DEF-1:0] dest;
    logic                  write_en;
    logic                  read;
    logic                  jmp_op;
    logic                  jmp_relative_op;
    logic [A_BITS_DEF-1:0] jmp_val;
    logic                  halt_op;
  } payload_t;
  localparam int PAYLOAD_BITS = $bits(payload_t);
  localparam payload_t PAYLOAD_ZERO = '0;
endpackage

// File: rtl/pipe_reg_skid_slot.sv
// pipe_slot: one valid bit plus payload register; clear beats load, load beats drop
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clear,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] load_data,
  output logic         valid,
  output logic [W-1:0] data
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  // drop empties the slot but keeps the payload bits as they were
  always_comb begin
    valid_d = clear ? 1'b0 : load ? 1'b1 : drop ? 1'b0 : valid_q;
    data_d  = clear ? '0 : load ? load_data : data_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: two-entry execute->writeback skid register with flush, sticky halt and occupancy
module pipe_reg_skid
  import pipe_reg_skid_pkg::*;
#(
  parameter int A_BITS = A_BITS_DEF,
  parameter int D_BITS = D_BITS_DEF,
  parameter int R_BITS = R_BITS_DEF
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D_BITS-1:0] in_result,
  input  logic [R_BITS-1:0] in_dest,
  input  logic [A_BITS-1:0] in_jmp_val,
  input  logic              in_write_en,
  input  logic              in_read,
  input  logic              in_jmp_op,
  input  logic              in_jmp_relative_op,
  input  logic              in_halt_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [D_BITS-1:0] out_result,
  output logic [R_BITS-1:0] out_dest,
  output logic [A_BITS-1:0] out_jmp_val,
  output logic              out_write_en,
  output logic              out_read,
  output logic              out_jmp_op,
  output logic              out_jmp_relative_op,
  output logic              out_halt_op,
  output logic              halted,
  output logic [1:0]        occupancy
);
  localparam int PW = D_BITS + R_BITS + A_BITS + 5;
  logic [PW-1:0] in_data, main_data, skid_data, main_in;
  logic main_valid, skid_valid, halted_q, halted_d;
  logic in_fire, out_fire, main_load, main_drop, skid_load, skid_drop;
  assign in_data = {in_result, in_dest, in_write_en, in_read, in_jmp_op,
                    in_jmp_relative_op, in_jmp_val, in_halt_op};
  assign in_ready = !skid_valid & !halted_q;
  // in_fire is never set while skid holds data, so main refills from skid first
  always_comb begin
    in_fire   = in_valid & in_ready;
    out_fire  = main_valid & out_ready;
    main_load = (in_fire & (!main_valid | out_fire)) | (out_fire & skid_valid);
    main_in   = skid_valid ? skid_data : in_data;
    main_drop = out_fire & !main_load;
    skid_load = in_fire & main_valid & !out_fire;
    skid_drop = out_fire & skid_valid;
    halted_d  = flush ? 1'b0 : halted_q | (in_fire & in_halt_op);
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) halted_q <= 1'b0;
    else       halted_q <= halted_d;
  end
  pipe_slot #(.W(PW)) u_main (
    .clk(clk), .nrst(nrst), .clear(flush), .load(main_load), .drop(main_drop),
    .load_data(main_in), .valid(main_valid), .data(main_data)
  );
  pipe_slot #(.W(PW)) u_skid (
    .clk(clk), .nrst(nrst), .clear(flush), .load(skid_load), .drop(skid_drop),
    .load_data(in_data), .valid(skid_valid), .data(skid_data)
  );
  assign {out_result, out_dest, out_write_en, out_read, out_jmp_op,
          out_jmp_relative_op, out_jmp_val, out_halt_op} = main_data;
  assign out_valid = main_valid;
  assign halted    = halted_q;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: scoreboard bench; the stage is modelled as an in-order queue of capacity two
module tb_pipe_reg_skid;
  import pipe_reg_skid_pkg::*;
  logic clk = 1'b0, nrst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, halted;
  logic [1:0] occupancy;
  logic [D_BITS_DEF-1:0] in_result, out_result;
  logic [R_BITS_DEF-1:0] in_dest, out_dest;
  logic [A_BITS_DEF-1:0] in_jmp_val, out_jmp_val;
  logic in_write_en, in_read, in_jmp_op, in_jmp_relative_op, in_halt_op;
  logic out_write_en, out_read, out_jmp_op, out_jmp_relative_op, out_halt_op;
  int total = 0, bad = 0;
  payload_t exp_q[$];
  logic halt_m = 1'b0;
  always #5 clk = ~clk;
  pipe_reg_skid dut (
    .clk(clk), .nrst(nrst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_dest(in_dest), .in_jmp_val(in_jmp_val),
    .in_write_en(in_write_en), .in_read(in_read), .in_jmp_op(in_jmp_op),
    .in_jmp_relative_op(in_jmp_relative_op), .in_halt_op(in_halt_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dest(out_dest), .out_jmp_val(out_jmp_val), .out_write_en(out_write_en),
    .out_read(out_read), .out_jmp_op(out_jmp_op), .out_jmp_relative_op(out_jmp_relative_op),
    .out_halt_op(out_halt_op), .halted(halted), .occupancy(occupancy)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic payload_t out_p();
    payload_t p;
    p = {out_result, out_dest, out_write_en, out_read, out_jmp_op,
         out_jmp_relative_op, out_jmp_val, out_halt_op};
    return p;
  endfunction
  function automatic payload_t rnd_p(input bit halt);
    logic [63:0] r;
    payload_t p;
    r = {$urandom, $urandom};
    p = r[PAYLOAD_BITS-1:0];
    p.halt_op = halt;
    return p;
  endfunction
  function automatic payload_t mk(input logic [31:0] res, input logic [2:0] dst, input bit halt);
    payload_t p;
    p = rnd_p(halt);
    p.result = res;
    p.dest = dst;
    return p;
  endfunction
  task automatic drive(input payload_t p);
    {in_result, in_dest, in_write_en, in_read, in_jmp_op,
     in_jmp_relative_op, in_jmp_val, in_halt_op} = p;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // upstream: hold the entry until in_ready is seen before an edge, with a bound
  task automatic send(input payload_t p);
    bit acc;
    int n;
    in_valid = 1'b1;
    drive(p);
    n = 0;
    do begin
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 40);
    if (!acc) chk("send_timeout", 64'(n), 64'(0));
    in_valid = 1'b0;
  endtask
  // monitor: compare against the queue model, then advance it with this cycle's handshakes
  always @(negedge clk) begin
    if (!nrst) begin
      exp_q.delete();
      halt_m = 1'b0;
    end else begin
      bit rdy_m;
      rdy_m = (exp_q.size() < 2) && !halt_m;
      chk("in_ready", 64'(in_ready), 64'(rdy_m));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("halted", 64'(halted), 64'(halt_m));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) chk("payload", 64'(out_p()), 64'(exp_q[0]));
      if (flush) begin
        exp_q.delete();
        halt_m = 1'b0;
      end else begin
        if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && rdy_m) begin
          exp_q.push_back(out_p_in());
          if (in_halt_op) halt_m = 1'b1;
        end
      end
    end
  end
  function automatic payload_t out_p_in();
    payload_t p;
    p = {in_result, in_dest, in_write_en, in_read, in_jmp_op,
         in_jmp_relative_op, in_jmp_val, in_halt_op};
    return p;
  endfunction
  initial begin
    payload_t cur;
    bit acc;
    drive(PAYLOAD_ZERO);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_payload", 64'(out_p()), 64'(PAYLOAD_ZERO));
    step();
    step();
    nrst = 1'b1;
    // streaming with out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(mk(32'h11 + 32'(i), 3'(i), 1'b0));
    step();
    step();
    chk("stream_drained", 64'(occupancy), 64'(0));
    // stall: A1 in main, A2 in skid, A3 held upstream
    out_ready = 1'b0;
    send(mk(32'hA1, 3'd1, 1'b0));
    send(mk(32'hA2, 3'd2, 1'b0));
    in_valid = 1'b1;
    drive(mk(32'hA3, 3'd3, 1'b0));
    step();
    chk("stall_occ", 64'(occupancy), 64'(2));
    chk("stall_ready", 64'(in_ready), 64'(0));
    chk("stall_head", 64'(out_result), 64'(32'hA1));
    out_ready = 1'b1;
    send(mk(32'hA3, 3'd3, 1'b0));
    for (int i = 0; i < 4; i++) step();
    chk("stall_drained", 64'(occupancy), 64'(0));
    // halt: later entries must never be accepted
    send(mk(32'hB0, 3'd5, 1'b1));
    chk("halt_set", 64'(halted), 64'(1));
    chk("halt_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    drive(mk(32'hB1, 3'd6, 1'b0));
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    chk("halt_still", 64'(halted), 64'(1));
    chk("halt_empty", 64'(occupancy), 64'(0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("halt_flushed", 64'(halted), 64'(0));
    // flush with both entries full and a valid input in the flush cycle
    out_ready = 1'b0;
    send(mk(32'hC1, 3'd1, 1'b0));
    send(mk(32'hC2, 3'd2, 1'b0));
    in_valid = 1'b1;
    flush = 1'b1;
    drive(mk(32'hC3, 3'd3, 1'b0));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_payload", 64'(out_p()), 64'(PAYLOAD_ZERO));
    chk("flush_ready", 64'(in_ready), 64'(1));
    // async reset mid-cycle with two entries and halted
    send(mk(32'hD1, 3'd1, 1'b0));
    send(mk(32'hD2, 3'd2, 1'b1));
    chk("pre_rst_halted", 64'(halted), 64'(1));
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_occ", 64'(occupancy), 64'(0));
    chk("arst_halted", 64'(halted), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_payload", 64'(out_p()), 64'(PAYLOAD_ZERO));
    step();
    nrst = 1'b1;
    // random traffic
    cur = rnd_p(1'b0);
    acc = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      bit r;
      if (acc || !in_valid) cur = rnd_p($urandom_range(49) == 0);
      in_valid = $urandom_range(3) != 0;
      out_ready = $urandom_range(2) != 0;
      flush = $urandom_range(59) == 0;
      drive(cur);
      r = in_ready;
      out_ready = !out_ready;
      #1;
      chk("ready_indep", 64'(in_ready), 64'(r));
      out_ready = !out_ready;
      acc = in_valid && in_ready;
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("final_empty", 64'(occupancy), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
